// File: rtl/regfile_pkg.sv
// Shared defaults, vector typedefs and the write-port arbitration helper for regfile_mp.
package regfile_pkg;

  localparam int ADDRW_DEF = 2;
  localparam int DATAW_DEF = 8;
  localparam int NWR_DEF   = 2;
  localparam int NRD_DEF   = 2;

  // Arbitration works on padded vectors so one function serves every port/address width.
  localparam int MAXP  = 8;
  localparam int MAXA  = 16;
  localparam int PIDXW = $clog2(MAXP);

  typedef logic [ADDRW_DEF-1:0] addr_t;
  typedef logic [DATAW_DEF-1:0] data_t;

  typedef logic [MAXP-1:0][MAXA-1:0] waddr_vec_t;

  typedef struct packed {
    logic             hit;
    logic             multi;
    logic [PIDXW-1:0] idx;
  } win_t;

  // Highest enabled port whose address matches wins; multi flags a second match.
  function automatic win_t win_port(input logic [MAXP-1:0] wen,
                                    input waddr_vec_t      waddr,
                                    input logic [MAXA-1:0] addr);
    win_t r;
    r = '0;
    for (int p = 0; p < MAXP; p++) begin
      if (wen[p] && (waddr[p] == addr)) begin
        if (r.hit) r.multi = 1'b1;
        r.hit = 1'b1;
        r.idx = PIDXW'(p);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_wsel.sv
// Per-entry write selector: entry enable, winning data and collision flag for one address.
module regfile_wsel
  import regfile_pkg::*;
#(
  parameter int ADDRW = ADDRW_DEF,
  parameter int DATAW = DATAW_DEF,
  parameter int NWR   = NWR_DEF,
  parameter int ENTRY = 0
) (
  input  logic [NWR-1:0]       i_wen,
  input  logic [NWR*ADDRW-1:0] i_waddr,
  input  logic [NWR*DATAW-1:0] i_wdata,
  output logic                 o_we,
  output logic [DATAW-1:0]     o_wdata,
  output logic                 o_coll
);

  logic [MAXP-1:0] wen_pad;
  waddr_vec_t      waddr_pad;
  win_t            win;

  // NWR must not exceed MAXP and ADDRW must not exceed MAXA.
  always_comb begin
    wen_pad   = '0;
    waddr_pad = '0;
    for (int w = 0; w < NWR; w++) begin
      wen_pad[w]   = i_wen[w];
      waddr_pad[w] = MAXA'(i_waddr[w*ADDRW +: ADDRW]);
    end
    win     = win_port(wen_pad, waddr_pad, MAXA'(ENTRY));
    o_we    = win.hit;
    o_coll  = win.multi;
    o_wdata = '0;
    for (int w = 0; w < NWR; w++) begin
      if (PIDXW'(w) == win.idx) o_wdata = i_wdata[w*DATAW +: DATAW];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, written tracking and collision reporting.
// Define REGFILE_MP_BYPASS_EN for write-first forwarding; default is read-first.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int               ADDRW  = ADDRW_DEF,
  parameter int               DATAW  = DATAW_DEF,
  parameter int               NWR    = NWR_DEF,
  parameter int               NRD    = NRD_DEF,
  parameter logic [DATAW-1:0] RSTVAL = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NWR-1:0]       i_wen,
  input  logic [NWR*ADDRW-1:0] i_waddr,
  input  logic [NWR*DATAW-1:0] i_wdata,
  input  logic [NRD-1:0]       i_ren,
  input  logic [NRD*ADDRW-1:0] i_raddr,
  output logic [NRD*DATAW-1:0] o_rdata,
  output logic [NRD-1:0]       o_rvalid,
  output logic [NRD-1:0]       o_rwritten,
  output logic                 o_collision
);

  localparam int DEPTH = 1 << ADDRW;

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [DATAW-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;

  logic [DEPTH-1:0] ent_we;
  logic [DEPTH-1:0] ent_coll;
  logic [DATAW-1:0] ent_wd [DEPTH];

  logic [NRD*DATAW-1:0] rdata_q, rdata_d;
  logic [NRD-1:0]       rvalid_q, rvalid_d;
  logic [NRD-1:0]       rwritten_q, rwritten_d;
  logic                 collision_q, collision_d;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      regfile_wsel #(
        .ADDRW (ADDRW),
        .DATAW (DATAW),
        .NWR   (NWR),
        .ENTRY (gi)
      ) u_wsel (
        .i_wen   (i_wen),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .o_we    (ent_we[gi]),
        .o_wdata (ent_wd[gi]),
        .o_coll  (ent_coll[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e]     = ent_we[e] ? ent_wd[e] : mem_q[e];
      written_d[e] = written_q[e] | ent_we[e];
    end
    collision_d = |ent_coll;
  end

  // Disabled read ports keep their last data and written flag.
  always_comb begin
    rdata_d    = rdata_q;
    rwritten_d = rwritten_q;
    rvalid_d   = i_ren;
    for (int r = 0; r < NRD; r++) begin
      if (i_ren[r]) begin
`ifdef REGFILE_MP_BYPASS_EN
        rdata_d[r*DATAW +: DATAW] = mem_d[i_raddr[r*ADDRW +: ADDRW]];
        rwritten_d[r]             = written_d[i_raddr[r*ADDRW +: ADDRW]];
`else
        rdata_d[r*DATAW +: DATAW] = mem_q[i_raddr[r*ADDRW +: ADDRW]];
        rwritten_d[r]             = written_q[i_raddr[r*ADDRW +: ADDRW]];
`endif
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= RSTVAL;
      written_q   <= '0;
      rdata_q     <= '0;
      rvalid_q    <= '0;
      rwritten_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= mem_d[e];
      written_q   <= written_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      rwritten_q  <= rwritten_d;
      collision_q <= collision_d;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_rwritten  = rwritten_q;
  assign o_collision = collision_q;

endmodule
